id_ex_stage: RTL and testbench

ID/EX pipeline register for the in-order core. It obeys the hazard unit's `stall`, `forward_rs1` and `forward_rs2` outputs: it inserts bubbles on a stall and resolves each source operand from three places, the EX result, the WB write port, or the register file. It drives the `id_ex_valid`, `id_ex_wb_we` and `id_ex_rd` fields that the hazard unit reads back, closing the detection/resolution loop between ID and EX.

---
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: stall bubbles, flush squash, per-source operand bypass.
// Optional ID_EX_PERF_EN adds bubble/flush event counters.

module id_ex_opsel #(
   parameter int XLEN = 32
) (
   input  logic [4:0]      rs_i,
   input  logic            fwd_i,
   input  logic [XLEN-1:0] ex_result_i,
   input  logic            wb_we_i,
   input  logic [4:0]      wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic [XLEN-1:0] rf_data_i,
   output logic [XLEN-1:0] op_o
);
   // x0 beats every bypass source, including the EX forward.
   always_comb begin
      op_o = rf_data_i;
      if (rs_i == 5'd0)                    op_o = '0;
      else if (fwd_i)                      op_o = ex_result_i;
      else if (wb_we_i && wb_rd_i == rs_i) op_o = wb_data_i;
   end
endmodule

module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int OPW  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_id_valid,
   input  logic [31:0]     if_id_pc,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   input  logic            dec_wb_we,
   input  logic [OPW-1:0]  dec_alu_op,
   input  logic [XLEN-1:0] dec_imm,
   input  logic [XLEN-1:0] rf_rs1_data,
   input  logic [XLEN-1:0] rf_rs2_data,
   input  logic            stall,
   input  logic            forward_rs1,
   input  logic            forward_rs2,
   input  logic [XLEN-1:0] ex_result,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            if_id_hold,
   output logic            id_ex_valid,
   output logic            id_ex_wb_we,
   output logic [4:0]      id_ex_rd,
   output logic [31:0]     id_ex_pc,
   output logic [XLEN-1:0] id_ex_op_a,
   output logic [XLEN-1:0] id_ex_op_b,
   output logic [XLEN-1:0] id_ex_imm,
   output logic [OPW-1:0]  id_ex_alu_op
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]     perf_bubbles,
   output logic [31:0]     perf_flushes
`endif
);
   localparam int NSRC = 2;

   logic [NSRC-1:0][4:0]      rs_idx;
   logic [NSRC-1:0]           fwd;
   logic [NSRC-1:0][XLEN-1:0] rf_data;
   logic [NSRC-1:0][XLEN-1:0] op_res;

   assign rs_idx  = {rs2, rs1};
   assign fwd     = {forward_rs2, forward_rs1};
   assign rf_data = {rf_rs2_data, rf_rs1_data};

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      id_ex_opsel #(.XLEN(XLEN)) u_opsel (
         .rs_i       (rs_idx[g]),
         .fwd_i      (fwd[g]),
         .ex_result_i(ex_result),
         .wb_we_i    (wb_we),
         .wb_rd_i    (wb_rd),
         .wb_data_i  (wb_data),
         .rf_data_i  (rf_data[g]),
         .op_o       (op_res[g])
      );
   end

   logic            valid_q, valid_d;
   logic            we_q, we_d;
   logic [4:0]      rd_q, rd_d;
   logic [31:0]     pc_q, pc_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
   logic [OPW-1:0]  op_q, op_d;
   logic            capture;

   // Every non-capture edge is a bubble; it clears rd/we so the hazard unit sees nothing.
   assign capture    = if_id_valid && !stall && !flush;
   assign if_id_hold = stall && !flush;

   always_comb begin
      valid_d = capture;
      we_d    = capture && dec_wb_we;
      rd_d    = capture ? rd : 5'd0;
      pc_d    = pc_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      op_d    = op_q;
      if (capture) begin
         pc_d  = if_id_pc;
         a_d   = op_res[0];
         b_d   = op_res[1];
         imm_d = dec_imm;
         op_d  = dec_alu_op;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         rd_q    <= '0;
         pc_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         op_q    <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         rd_q    <= rd_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         op_q    <= op_d;
      end
   end

   assign id_ex_valid  = valid_q;
   assign id_ex_wb_we  = we_q;
   assign id_ex_rd     = rd_q;
   assign id_ex_pc     = pc_q;
   assign id_ex_op_a   = a_q;
   assign id_ex_op_b   = b_q;
   assign id_ex_imm    = imm_q;
   assign id_ex_alu_op = op_q;

`ifdef ID_EX_PERF_EN
   logic [31:0] bub_q, bub_d, fl_q, fl_d;

   assign bub_d = bub_q + {31'd0, if_id_hold};
   assign fl_d  = fl_q + {31'd0, flush};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bub_q <= '0;
         fl_q  <= '0;
      end else begin
         bub_q <= bub_d;
         fl_q  <= fl_d;
      end
   end

   assign perf_bubbles = bub_q;
   assign perf_flushes = fl_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + randomized bench for id_ex_stage against a rule-level reference model.
// Checks perf counters too when ID_EX_PERF_EN is defined.

module tb_id_ex_stage;
   localparam int XLEN = 32;
   localparam int OPW  = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            if_id_valid = 1'b0;
   logic [31:0]     if_id_pc = '0;
   logic [4:0]      rs1 = '0, rs2 = '0, rd = '0;
   logic            dec_wb_we = 1'b0;
   logic [OPW-1:0]  dec_alu_op = '0;
   logic [XLEN-1:0] dec_imm = '0;
   logic [XLEN-1:0] rf_rs1_data = '0, rf_rs2_data = '0;
   logic            stall = 1'b0, forward_rs1 = 1'b0, forward_rs2 = 1'b0;
   logic [XLEN-1:0] ex_result = '0;
   logic            wb_we = 1'b0;
   logic [4:0]      wb_rd = '0;
   logic [XLEN-1:0] wb_data = '0;
   logic            flush = 1'b0;
   logic            if_id_hold, id_ex_valid, id_ex_wb_we;
   logic [4:0]      id_ex_rd;
   logic [31:0]     id_ex_pc;
   logic [XLEN-1:0] id_ex_op_a, id_ex_op_b, id_ex_imm;
   logic [OPW-1:0]  id_ex_alu_op;
`ifdef ID_EX_PERF_EN
   logic [31:0]     perf_bubbles, perf_flushes;
`endif

   id_ex_stage #(.XLEN(XLEN), .OPW(OPW)) dut (
      .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .dec_wb_we(dec_wb_we), .dec_alu_op(dec_alu_op),
      .dec_imm(dec_imm), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .stall(stall), .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
      .ex_result(ex_result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .if_id_hold(if_id_hold), .id_ex_valid(id_ex_valid),
      .id_ex_wb_we(id_ex_wb_we), .id_ex_rd(id_ex_rd), .id_ex_pc(id_ex_pc),
      .id_ex_op_a(id_ex_op_a), .id_ex_op_b(id_ex_op_b), .id_ex_imm(id_ex_imm),
      .id_ex_alu_op(id_ex_alu_op)
`ifdef ID_EX_PERF_EN
      , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
   );

   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;

   // Reference state
   logic            e_valid, e_we;
   logic [4:0]      e_rd;
   logic [31:0]     e_pc, e_bub, e_fl;
   logic [XLEN-1:0] e_a, e_b, e_imm;
   logic [OPW-1:0]  e_op;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] pick(input logic [4:0] r, input logic f,
                                            input logic [XLEN-1:0] rf);
      if (r == 0) return '0;
      if (f) return ex_result;
      if (wb_we && wb_rd == r) return wb_data;
      return rf;
   endfunction

   task automatic model_reset();
      e_valid = 0; e_we = 0; e_rd = 0; e_pc = 0; e_a = 0; e_b = 0;
      e_imm = 0; e_op = 0; e_bub = 0; e_fl = 0;
   endtask

   task automatic model_edge();
      if (flush) begin
         e_valid = 0; e_we = 0; e_rd = 0; e_fl = e_fl + 1;
      end else if (stall) begin
         e_valid = 0; e_we = 0; e_rd = 0; e_bub = e_bub + 1;
      end else if (if_id_valid) begin
         e_valid = 1; e_we = dec_wb_we; e_rd = rd; e_pc = if_id_pc;
         e_a = pick(rs1, forward_rs1, rf_rs1_data);
         e_b = pick(rs2, forward_rs2, rf_rs2_data);
         e_imm = dec_imm; e_op = dec_alu_op;
      end else begin
         e_valid = 0; e_we = 0; e_rd = 0;
      end
   endtask

   task automatic check_all(input string tag, input logic all_data);
      check({tag, ".valid"}, 32'(id_ex_valid), 32'(e_valid));
      check({tag, ".wb_we"}, 32'(id_ex_wb_we), 32'(e_we));
      check({tag, ".rd"},    32'(id_ex_rd),    32'(e_rd));
      if (e_valid || all_data) begin
         check({tag, ".pc"},  id_ex_pc,   e_pc);
         check({tag, ".a"},   id_ex_op_a, e_a);
         check({tag, ".b"},   id_ex_op_b, e_b);
         check({tag, ".imm"}, id_ex_imm,  e_imm);
         check({tag, ".op"},  32'(id_ex_alu_op), 32'(e_op));
      end
`ifdef ID_EX_PERF_EN
      check({tag, ".perf_bub"}, perf_bubbles, e_bub);
      check({tag, ".perf_fl"},  perf_flushes, e_fl);
`endif
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag, 1'b0);
   endtask

   task automatic set_instr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                            input logic [31:0] va, input logic [31:0] vb);
      if_id_valid = 1; rs1 = a; rs2 = b; rd = d; rf_rs1_data = va; rf_rs2_data = vb;
      if_id_pc = 32'h100 + 32'(d); dec_wb_we = 1; dec_alu_op = 4'h1; dec_imm = 32'h10;
   endtask

   task automatic clear_ctl();
      stall = 0; flush = 0; forward_rs1 = 0; forward_rs2 = 0; wb_we = 0;
   endtask

   initial begin
      model_reset();
      #1;
      check_all("reset", 1'b1);
      check("reset.hold", 32'(if_id_hold), 32'd0);
      @(negedge clk);
      rst = 0;

      // Plain capture
      set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
      step("add");
      check("add.a_const", id_ex_op_a, 32'd5);
      check("add.b_const", id_ex_op_b, 32'd7);

      // One-cycle stall, then recapture through the WB bypass
      stall = 1;
      #1 check("stall.hold", 32'(if_id_hold), 32'd1);
      step("stall");
      stall = 0; wb_we = 1; wb_rd = 5'd1; wb_data = 32'h1234;
      step("recap");
      check("recap.a_const", id_ex_op_a, 32'h1234);

      // Forward beats WB bypass
      clear_ctl();
      set_instr(5'd4, 5'd6, 5'd7, 32'd1, 32'd2);
      forward_rs2 = 1; ex_result = 32'hDEAD; wb_we = 1; wb_rd = 5'd6; wb_data = 32'hBEEF;
      step("fwd");
      check("fwd.b_const", id_ex_op_b, 32'hDEAD);

      // x0 ignores WB hit
      clear_ctl();
      set_instr(5'd0, 5'd2, 5'd8, 32'h55, 32'h66);
      wb_we = 1; wb_rd = 5'd0; wb_data = 32'hFFFF;
      step("x0");
      check("x0.a_const", id_ex_op_a, 32'd0);

      // Flush + stall together
      clear_ctl();
      flush = 1; stall = 1;
      #1 check("flst.hold", 32'(if_id_hold), 32'd0);
      step("flst");

      // Back-to-back stalls
      clear_ctl();
      stall = 1;
      for (int i = 0; i < 3; i++) step("b2b");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if_id_valid = ($urandom_range(0, 3) != 0);
         if_id_pc    = $urandom;
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
         rd  = 5'($urandom_range(0, 31));
         dec_wb_we = 1'($urandom_range(0, 1));
         dec_alu_op = 4'($urandom_range(0, 15));
         dec_imm = $urandom; rf_rs1_data = $urandom; rf_rs2_data = $urandom;
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         forward_rs1 = ($urandom_range(0, 3) == 0);
         forward_rs2 = ($urandom_range(0, 3) == 0);
         ex_result = $urandom;
         wb_we = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
         #1 check("rnd.hold", 32'(if_id_hold), 32'(stall && !flush));
         step("rnd");
      end

      // Asynchronous reset mid-stream
      clear_ctl();
      set_instr(5'd9, 5'd10, 5'd11, 32'hA, 32'hB);
      step("pre_rst");
      rst = 1;
      #1;
      model_reset();
      check_all("async_rst", 1'b1);
      #2 rst = 0;
      set_instr(5'd1, 5'd2, 5'd12, 32'h77, 32'h88);
      step("post_rst");

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
